// File: rtl/pcs_tx_seq_if.sv
// Transmit block stream between the XGMII-side encoder and the PCS sequencer.
// The master drives a classified block with tx_valid and receives the sequenced block with blk_out_valid.
interface pcs_tx_seq_if;
  logic        tx_valid;
  logic [2:0]  t_type;
  logic [65:0] blk_in;
  logic [65:0] blk_out;
  logic        blk_out_valid;

  modport master (
    output tx_valid,
    output t_type,
    output blk_in,
    input  blk_out,
    input  blk_out_valid
  );

  modport slave (
    input  tx_valid,
    input  t_type,
    input  blk_in,
    output blk_out,
    output blk_out_valid
  );
endinterface

// File: rtl/pcs_tx_seq.sv
// 64b/66b transmit sequencer: checks block ordering, substitutes error/local-fault blocks. Optional PCS_TX_ERR_CNT_EN adds a substitution counter.
// Latency: 1 clk from tx_valid to blk_out/blk_out_valid.
// Backpressure: none; tx_valid=0 holds state, blk_out and err_cnt, and drops blk_out_valid.
module pcs_tx_seq (
  input  logic             clk,
  input  logic             rst_n,
  pcs_tx_seq_if.slave      bus,
  input  logic             lf_force,
  input  logic             err_clr,
  output logic [2:0]       state,
  output logic [15:0]      err_cnt
);

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_C    = 3'd1,
    ST_D    = 3'd2,
    ST_T    = 3'd3,
    ST_E    = 3'd4
  } st_e;

  localparam logic [2:0] TT_S = 3'd0;
  localparam logic [2:0] TT_C = 3'd1;
  localparam logic [2:0] TT_D = 3'd3;
  localparam logic [2:0] TT_T = 3'd4;

  localparam logic [65:0] EBLOCK = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [65:0] LBLOCK = {32'h0, 8'h01, 8'h00, 8'h00, 8'h4B, 2'b01};

  st_e         state_q;
  st_e         state_nxt;
  logic [65:0] blk_q;
  logic [65:0] blk_nxt;
  logic        vld_q;

  always_comb begin
    state_nxt = state_q;
    blk_nxt   = blk_q;
    if (bus.tx_valid) begin
      if (lf_force) begin
        state_nxt = ST_INIT;
      end else begin
        case (state_q)
          // Inside a frame only further data or the terminate block is legal.
          ST_D: begin
            case (bus.t_type)
              TT_D:    state_nxt = ST_D;
              TT_T:    state_nxt = ST_T;
              default: state_nxt = ST_E;
            endcase
          end
          // Error state resynchronises on any well-formed block class.
          ST_E: begin
            case (bus.t_type)
              TT_S:    state_nxt = ST_D;
              TT_C:    state_nxt = ST_C;
              TT_D:    state_nxt = ST_D;
              TT_T:    state_nxt = ST_T;
              default: state_nxt = ST_E;
            endcase
          end
          default: begin
            case (bus.t_type)
              TT_S:    state_nxt = ST_D;
              TT_C:    state_nxt = ST_C;
              default: state_nxt = ST_E;
            endcase
          end
        endcase
      end

      case (state_nxt)
        ST_INIT: blk_nxt = LBLOCK;
        ST_E:    blk_nxt = EBLOCK;
        default: blk_nxt = bus.blk_in;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      blk_q   <= LBLOCK;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      blk_q   <= blk_nxt;
      vld_q   <= bus.tx_valid;
    end
  end

  assign state             = state_q;
  assign bus.blk_out       = blk_q;
  assign bus.blk_out_valid = vld_q;

`ifdef PCS_TX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Clear takes precedence over a same-cycle substitution.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0000;
    end else if (err_clr) begin
      err_cnt_q <= 16'h0000;
    end else if (bus.tx_valid && (state_nxt == ST_E) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h0001;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_cnt        = 16'h0000;
`endif

endmodule

// File: tb/tb_pcs_tx_seq.sv
// Self-checking bench for pcs_tx_seq: directed table, hand sequences and randomized traffic against a rule-based model.
module tb_pcs_tx_seq;

`ifdef PCS_TX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [65:0] EBLK = {{8{7'h1E}}, 8'h1E, 2'b01};
  localparam logic [65:0] LBLK = {32'h0, 8'h01, 8'h00, 8'h00, 8'h4B, 2'b01};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lf_force;
  logic        err_clr;
  logic [2:0]  state;
  logic [15:0] err_cnt;

  pcs_tx_seq_if bus();

  pcs_tx_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .lf_force (lf_force),
    .err_clr  (err_clr),
    .state    (state),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;

  int          m_state;
  logic [65:0] m_blk;
  logic        m_vld;
  logic [15:0] m_cnt;

  typedef struct {
    bit       v;
    bit [2:0] t;
    bit       lf;
    bit [2:0] es;
    bit [1:0] ek;   // 0: blk_in, 1: EBLOCK, 2: LBLOCK, 3: hold previous
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sequencing rules: C always legal outside a frame, S opens a frame,
  // D/T only continue a frame (or recover from E), anything else is an error.
  function automatic int m_next(input int cur, input int t);
    int  tt;
    bit  in_frame;
    bit  from_err;
    tt       = (t > 4) ? 2 : t;
    in_frame = (cur == 2);
    from_err = (cur == 4);
    case (tt)
      1:       return in_frame ? 4 : 1;
      0:       return in_frame ? 4 : 2;
      3:       return (in_frame || from_err) ? 2 : 4;
      4:       return (in_frame || from_err) ? 3 : 4;
      default: return 4;
    endcase
  endfunction

  function automatic logic [65:0] rnd66();
    logic [95:0] x;
    x = {$urandom, $urandom, $urandom};
    return x[65:0];
  endfunction

  task automatic cycle(input bit rst, input bit v, input logic [2:0] t, input logic [65:0] b,
                       input bit lf, input bit clr, input bit do_chk);
    int nxt;
    rst_n        = !rst;
    bus.tx_valid = v;
    bus.t_type   = t;
    bus.blk_in   = b;
    lf_force     = lf;
    err_clr      = clr;
    if (rst) begin
      m_state = 0;
      m_blk   = LBLK;
      m_vld   = 1'b0;
      m_cnt   = 16'h0000;
    end else begin
      nxt = v ? (lf ? 0 : m_next(m_state, int'(t))) : m_state;
      if (CNT_EN) begin
        if (clr)                                        m_cnt = 16'h0000;
        else if (v && nxt == 4 && m_cnt != 16'hFFFF)    m_cnt = m_cnt + 16'h0001;
      end
      if (v) m_blk = (nxt == 0) ? LBLK : ((nxt == 4) ? EBLK : b);
      m_state = nxt;
      m_vld   = v;
    end
    @(posedge clk);
    #1;
    if (do_chk) begin
      chk("state",         66'(state),             66'(m_state));
      chk("blk_out",       bus.blk_out,            m_blk);
      chk("blk_out_valid", 66'(bus.blk_out_valid), 66'(m_vld));
      chk("err_cnt",       66'(err_cnt),           66'(m_cnt));
    end
  endtask

  initial begin
    logic [65:0] b;
    logic [65:0] exp_blk;
    int          guard;

    rst_n        = 1'b0;
    bus.tx_valid = 1'b0;
    bus.t_type   = 3'd1;
    bus.blk_in   = '0;
    lf_force     = 1'b0;
    err_clr      = 1'b0;
    m_state      = 0;
    m_blk        = LBLK;
    m_vld        = 1'b0;
    m_cnt        = 16'h0000;

    tbl[0]  = '{1'b1, 3'd1, 1'b0, 3'd1, 2'd0};  // C -> C
    tbl[1]  = '{1'b1, 3'd0, 1'b0, 3'd2, 2'd0};  // S -> D
    tbl[2]  = '{1'b1, 3'd3, 1'b0, 3'd2, 2'd0};
    tbl[3]  = '{1'b1, 3'd3, 1'b0, 3'd2, 2'd0};
    tbl[4]  = '{1'b1, 3'd4, 1'b0, 3'd3, 2'd0};  // T -> T
    tbl[5]  = '{1'b1, 3'd1, 1'b0, 3'd1, 2'd0};
    tbl[6]  = '{1'b1, 3'd0, 1'b0, 3'd2, 2'd0};
    tbl[7]  = '{1'b1, 3'd1, 1'b0, 3'd4, 2'd1};  // C inside frame -> E
    tbl[8]  = '{1'b1, 3'd1, 1'b0, 3'd1, 2'd0};  // E recovers on C
    tbl[9]  = '{1'b1, 3'd0, 1'b0, 3'd2, 2'd0};
    tbl[10] = '{1'b1, 3'd3, 1'b1, 3'd0, 2'd2};  // forced fault x3
    tbl[11] = '{1'b1, 3'd4, 1'b1, 3'd0, 2'd2};
    tbl[12] = '{1'b1, 3'd0, 1'b1, 3'd0, 2'd2};
    tbl[13] = '{1'b1, 3'd3, 1'b0, 3'd4, 2'd1};  // D from INIT -> E
    tbl[14] = '{1'b1, 3'd6, 1'b0, 3'd4, 2'd1};  // code 6 treated as E
    tbl[15] = '{1'b1, 3'd4, 1'b0, 3'd3, 2'd0};  // E -> T
    tbl[16] = '{1'b1, 3'd5, 1'b0, 3'd4, 2'd1};  // code 5 from T -> E
    tbl[17] = '{1'b1, 3'd3, 1'b0, 3'd2, 2'd0};  // E -> D
    tbl[18] = '{1'b0, 3'd1, 1'b0, 3'd2, 2'd3};  // idle cycles hold
    tbl[19] = '{1'b0, 3'd0, 1'b0, 3'd2, 2'd3};
    tbl[20] = '{1'b0, 3'd4, 1'b0, 3'd2, 2'd3};
    tbl[21] = '{1'b0, 3'd2, 1'b0, 3'd2, 2'd3};
    tbl[22] = '{1'b1, 3'd0, 1'b0, 3'd4, 2'd1};  // S inside frame -> E

    cycle(1'b1, 1'b1, 3'd3, rnd66(), 1'b0, 1'b0, 1'b1);
    chk("reset_state", 66'(state),             66'd0);
    chk("reset_blk",   bus.blk_out,            LBLK);
    chk("reset_vld",   66'(bus.blk_out_valid), 66'd0);
    chk("reset_cnt",   66'(err_cnt),           66'd0);

    exp_blk = LBLK;
    for (int i = 0; i < 23; i++) begin
      b = rnd66();
      cycle(1'b0, tbl[i].v, tbl[i].t, b, tbl[i].lf, 1'b0, 1'b1);
      case (tbl[i].ek)
        2'd0:    exp_blk = b;
        2'd1:    exp_blk = EBLK;
        2'd2:    exp_blk = LBLK;
        default: exp_blk = exp_blk;
      endcase
      chk($sformatf("tbl%0d_state", i), 66'(state), 66'(tbl[i].es));
      chk($sformatf("tbl%0d_blk", i), bus.blk_out, exp_blk);
    end
    chk("tbl_err_cnt", 66'(err_cnt), CNT_EN ? 66'd5 : 66'd0);

    // Reset mid-packet while in T, then T from INIT is illegal.
    cycle(1'b0, 1'b1, 3'd1, rnd66(), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 3'd0, rnd66(), 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 3'd4, rnd66(), 1'b0, 1'b0, 1'b1);
    chk("pre_rst_state", 66'(state), 66'd3);
    cycle(1'b1, 1'b1, 3'd1, rnd66(), 1'b0, 1'b0, 1'b1);
    chk("mid_rst_state", 66'(state),             66'd0);
    chk("mid_rst_blk",   bus.blk_out,            LBLK);
    chk("mid_rst_vld",   66'(bus.blk_out_valid), 66'd0);
    cycle(1'b0, 1'b1, 3'd4, rnd66(), 1'b0, 1'b0, 1'b1);
    chk("post_rst_state", 66'(state), 66'd4);
    chk("post_rst_blk",   bus.blk_out, EBLK);

    // Randomized traffic with occasional faults, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) == 0), ($urandom_range(9) < 8), 3'($urandom_range(7)), rnd66(),
            ($urandom_range(19) == 0), ($urandom_range(29) == 0), 1'b1);
    end

    // Counter saturation, then clear racing an E block.
    if (CNT_EN) begin
      guard = 0;
      while (m_cnt != 16'hFFFF && guard < 70000) begin
        cycle(1'b0, 1'b1, 3'd2, rnd66(), 1'b0, 1'b0, 1'b0);
        guard++;
      end
      chk("sat_reached", 66'(err_cnt), 66'hFFFF);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 3'd2, rnd66(), 1'b0, 1'b0, 1'b1);
      chk("sat_hold", 66'(err_cnt), CNT_EN ? 66'hFFFF : 66'd0);
    end
    cycle(1'b0, 1'b1, 3'd2, rnd66(), 1'b0, 1'b1, 1'b1);
    chk("clr_wins", 66'(err_cnt), 66'd0);
    cycle(1'b0, 1'b1, 3'd2, rnd66(), 1'b0, 1'b0, 1'b1);
    chk("after_clr", 66'(err_cnt), CNT_EN ? 66'd1 : 66'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcs_tx_seq.md
PCS_TX_SEQ -- requirements
Module: pcs_tx_seq

Interface
REQ-001 clk  input  1  transmit PCS clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-003 tx_valid  input  1  qualifies t_type and blk_in for the current cycle.
REQ-004 t_type  input  3  block class of the current XGMII word: S=0, C=1, E=2, D=3, T=4; codes 5-7 are treated as E.
REQ-005 blk_in  input  66  encoded 64b/66b block for the same word; [1:0] sync header, [9:2] block type.
REQ-006 lf_force  input  1  forces the sequencer to TX_INIT, for example on link fault or an encoder not ready.
REQ-007 err_clr  input  1  clears the substitution counter.
REQ-008 blk_out  output  66  registered block to the scrambler.
REQ-009 blk_out_valid  output  1  registered copy of the accepted tx_valid.
REQ-010 state  output  3  current state: INIT=0, C=1, D=2, T=3, E=4.
REQ-011 err_cnt  output  16  count of error blocks substituted.

Function
REQ-012 The block SHALL advance its state only in cycles where tx_valid=1.
  - It SHALL load blk_out in the same cycles.
  - Latency from tx_valid to blk_out is exactly 1 clk.
REQ-013 With tx_valid=0, the block SHALL hold state, blk_out and err_cnt, and drive blk_out_valid=0 on the next cycle.
REQ-014 Next-state transitions SHALL be as follows.
  - INIT: C->C, S->D, else->E.
  - C: C->C, S->D, else->E.
  - D: D->D, T->T, else->E.
  - T: C->C, S->D, else->E.
  - E: C->C, S->D, D->D, T->T, E->E.
REQ-015 blk_out SHALL be blk_in when the next state is C, D or T.
  - It SHALL be EBLOCK when the next state is E.
  - It SHALL be LBLOCK when the next state is INIT.
REQ-016 EBLOCK is fixed as follows.
  - [1:0] = 2'b01.
  - [9:2] = 8'h1E.
  - [65:10] = eight 7-bit fields, each 7'h1E.
REQ-017 LBLOCK is fixed as follows.
  - [1:0] = 2'b01.
  - [9:2] = 8'h4B.
  - [17:10] = 8'h00.
  - [25:18] = 8'h00.
  - [33:26] = 8'h01.
  - [65:34] = 0.
REQ-018 lf_force=1 SHALL move state to INIT and load blk_out=LBLOCK on the next edge whenever tx_valid=1, regardless of t_type.
REQ-019 While lf_force stays high with tx_valid=1, LBLOCK SHALL be emitted every valid cycle.
  - On release, the transitions follow REQ-014 from INIT.
REQ-020 Priority SHALL be rst_n, then lf_force, then the normal transition.

Reset
REQ-021 When rst_n=0 at a rising edge, the block SHALL set the following reset values.
  - state = INIT.
  - blk_out = LBLOCK.
  - blk_out_valid = 0.
  - err_cnt = 0.
REQ-022 A reset asserted mid-packet SHALL take effect on that edge with no partial block emitted.
  - The first valid block after release SHALL be evaluated from INIT.

Configuration
REQ-023 Macro PCS_TX_ERR_CNT_EN SHALL control the substitution counter.
  - Defined: err_cnt increments by 1 on each valid cycle whose next state is E.
  - err_cnt saturates at 16'hFFFF.
  - err_clr=1 sets err_cnt to 0 on the next edge; clear wins over a simultaneous increment.
  - Undefined: err_cnt is constant 0, err_clr is ignored, and no counter registers exist.

Verification
REQ-024 Reset, then t_type stream C,S,D,D,T,C with tx_valid=1 -> states C,D,D,D,T,C; blk_out equals blk_in each time; err_cnt=0.
REQ-025 From D, t_type=C -> state E and blk_out=EBLOCK; then t_type=C -> state C, blk_out=blk_in, err_cnt=1 (macro defined).
REQ-026 lf_force=1 for 3 valid cycles in state D -> three LBLOCKs with state=INIT; release with t_type=D -> state E and blk_out=EBLOCK.
REQ-027 tx_valid=0 for 4 cycles in state D with t_type toggling -> state and blk_out unchanged; blk_out_valid=0 throughout.
REQ-028 Preload err_cnt to 16'hFFFF with continuous E, then continue -> err_cnt stays at FFFF; err_clr together with an E block -> err_cnt=0.
REQ-029 rst_n=0 for one edge in state T -> state=INIT, blk_out=LBLOCK, blk_out_valid=0; next t_type=T -> state E.
